led_ctrl: RTL and testbench

Memory-mapped LED controller on the CPU data bus. It holds per-LED mode, static value, PWM duty and blink-rate registers. It drives a registered 4-bit LED vector into the downstream LED dimmer's `leds_i`. Provides static, blinking, PWM-brightness and forced-off modes per LED, independent of CPU activity once configured.

---
 rtl/led_ctrl.sv | 109 ++++++++++
 tb/tb_led_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_ctrl.sv
// Memory-mapped 4-LED controller: per-LED static/blink/PWM/off modes driven from
// LED_OUT, MODE, DUTY and BLINK_DIV registers; LED drive and read data are registered.
module led_ctrl #(
   parameter int              PWM_BITS  = 8,
   parameter int              DIV_WIDTH = 24,
   parameter logic [DIV_WIDTH-1:0] DIV_RESET = 24'd6_000_000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sel,
   input  logic [3:0]  mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   output logic [3:0]  leds_o
);

   // Bus handshake: a write happens on any rising edge where sel & |mem_wmask,
   // a read where sel & mem_rstrb; read data is valid the cycle after the strobe.
   logic                 wr_en, rd_en;
   logic [1:0]           idx;
   logic [31:0]          lane_mask;
   logic [3:0]           led_out;
   logic [7:0]           mode;
   logic [PWM_BITS-1:0]  duty [4];
   logic [DIV_WIDTH-1:0] blink_div, div_cnt, div_wr_val;
   logic                 blink_phase;
   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [3:0]           led_nxt;
   logic [31:0]          rd_view;
   logic                 unused_ok;

   assign wr_en     = sel & (|mem_wmask);
   assign rd_en     = sel & mem_rstrb;
   assign idx       = mem_addr[3:2];
   assign lane_mask = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}}, {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
   assign unused_ok = ^{mem_addr[1:0], lane_mask, mem_wdata};

   assign div_wr_val = (blink_div & ~lane_mask[DIV_WIDTH-1:0]) |
                       (mem_wdata[DIV_WIDTH-1:0] & lane_mask[DIV_WIDTH-1:0]);

   always_comb begin
      led_nxt = '0;
      for (int i = 0; i < 4; i++) begin
         case (mode[2*i +: 2])
            2'b00:   led_nxt[i] = led_out[i];
            2'b01:   led_nxt[i] = led_out[i] & blink_phase;
            2'b10:   led_nxt[i] = (pwm_cnt < duty[i]);
            default: led_nxt[i] = 1'b0;
         endcase
      end
   end

   always_comb begin
      rd_view = '0;
      case (idx)
         2'd0: rd_view[3:0] = led_out;
         2'd1: rd_view[7:0] = mode;
         2'd2: for (int i = 0; i < 4; i++) rd_view[8*i +: PWM_BITS] = duty[i];
         default: rd_view[DIV_WIDTH-1:0] = blink_div;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_out   <= '0;
         mode      <= '0;
         blink_div <= DIV_RESET;
         for (int i = 0; i < 4; i++) duty[i] <= '0;
      end else if (wr_en) begin
         case (idx)
            2'd0: if (mem_wmask[0]) led_out <= mem_wdata[3:0];
            2'd1: if (mem_wmask[0]) mode <= mem_wdata[7:0];
            2'd2: for (int i = 0; i < 4; i++)
                     if (mem_wmask[i]) duty[i] <= mem_wdata[8*i +: PWM_BITS];
            default: blink_div <= div_wr_val;
         endcase
      end
   end

   // A BLINK_DIV write restarts the interval but leaves the phase alone.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt     <= DIV_RESET;
         blink_phase <= 1'b0;
      end else if (wr_en && idx == 2'd3) begin
         div_cnt <= div_wr_val;
      end else if (div_cnt == '0) begin
         div_cnt     <= blink_div;
         blink_phase <= ~blink_phase;
      end else begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pwm_cnt   <= '0;
         leds_o    <= '0;
         mem_rdata <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         leds_o  <= led_nxt;
         if (rd_en) mem_rdata <= rd_view;
      end
   end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: bus tasks drive on the falling edge, expected values go into
// a queue as stimulus is issued and are popped when the DUT output is sampled.
module tb_led_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        sel = 1'b0;
   logic [3:0]  mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wmask = '0;
   logic        mem_rstrb = 1'b0;
   logic [31:0] mem_rdata;
   logic [3:0]  leds_o;

   logic [31:0] exp_q[$];
   int total = 0;
   int bad = 0;

   localparam logic [31:0] DIV_RST = 32'd6_000_000;

   led_ctrl dut (
      .clk(clk), .resetn(resetn), .sel(sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
      .mem_rdata(mem_rdata), .leds_o(leds_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // All bus tasks start and end on a falling edge.
   task automatic bus_cycle(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input logic rd);
      sel       = 1'b1;
      mem_addr  = addr;
      mem_wdata = data;
      mem_wmask = mask;
      mem_rstrb = rd;
      @(negedge clk);
      sel       = 1'b0;
      mem_wmask = '0;
      mem_rstrb = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] widx, input logic [31:0] data, input logic [3:0] mask);
      bus_cycle({widx, 2'b00}, data, mask, 1'b0);
   endtask

   task automatic read_check(input logic [1:0] ridx, input logic [31:0] exp, input string name);
      logic [31:0] e;
      exp_q.push_back(exp);
      bus_cycle({ridx, 2'b00}, 32'h0, 4'h0, 1'b1);
      e = exp_q.pop_front();
      total++;
      if (mem_rdata !== e) begin
         bad++;
         $display("FAIL %s: rdata=%h expected=%h", name, mem_rdata, e);
      end
   endtask

   task automatic leds_check(input logic [3:0] exp, input string name);
      total++;
      if (leds_o !== exp) begin
         bad++;
         $display("FAIL %s: leds_o=%b expected=%b", name, leds_o, exp);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      leds_check(4'b0000, "reset_leds");
      total++;
      if (mem_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_rdata: rdata=%h expected=0", mem_rdata);
      end
      resetn = 1'b1;
      @(negedge clk);
      read_check(2'd3, DIV_RST, "reset_blink_div");
      read_check(2'd1, 32'h0, "reset_mode");
      read_check(2'd0, 32'h0, "reset_led_out");
      read_check(2'd2, 32'h0, "reset_duty");
   endtask

   task automatic test_static();
      bus_write(2'd1, 32'h0, 4'h1);
      bus_write(2'd0, 32'hFFFF_FFFA, 4'hF);
      leds_check(4'b0000, "static_latency");
      @(negedge clk);
      leds_check(4'b1010, "static_value");
      bus_write(2'd1, 32'hC0, 4'h1);
      @(negedge clk);
      leds_check(4'b0010, "static_led3_off");
      read_check(2'd0, 32'h0000_000A, "led_out_unused_bits");
   endtask

   task automatic test_blink();
      logic [31:0] e;
      logic bit0;
      bus_write(2'd3, 32'd3, 4'hF);
      bus_write(2'd0, 32'h1, 4'h1);
      bus_write(2'd1, 32'h01, 4'h1);
      // t counts edges after the MODE write; phase first toggles at t=2, every 4 after.
      for (int t = 1; t <= 20; t++) begin
         bit0 = (t >= 3) && (((t - 3) % 8) < 4);
         exp_q.push_back({28'h0, 3'b000, bit0});
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (leds_o !== e[3:0]) begin
            bad++;
            $display("FAIL blink_t%0d: leds_o=%b expected=%b", t, leds_o, e[3:0]);
         end
      end
      // Rewrite at t=21 (counter would have hit 0): next toggle moves to t=25.
      for (int t = 21; t <= 30; t++) begin
         bit0 = (t <= 25) || (t >= 30);
         exp_q.push_back({28'h0, 3'b000, bit0});
      end
      bus_write(2'd3, 32'd3, 4'h1);
      for (int t = 21; t <= 30; t++) begin
         if (t > 21) @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (leds_o !== e[3:0]) begin
            bad++;
            $display("FAIL blink_restart_t%0d: leds_o=%b expected=%b", t, leds_o, e[3:0]);
         end
      end
   endtask

   task automatic pwm_measure(input logic [7:0] d, input int exp_hi, input int exp_run);
      int hi, run, max_run;
      logic [31:0] e;
      bus_write(2'd2, {24'h0, d}, 4'h1);
      @(negedge clk);
      exp_q.push_back(exp_hi);
      exp_q.push_back(exp_run);
      hi = 0; run = 0; max_run = 0;
      for (int c = 0; c < 512; c++) begin
         @(negedge clk);
         if (leds_o[0]) begin
            hi++; run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
      end
      e = exp_q.pop_front();
      total++;
      if (hi !== int'(e)) begin
         bad++;
         $display("FAIL pwm_high_duty%0d: high=%0d expected=%0d", d, hi, e);
      end
      e = exp_q.pop_front();
      total++;
      if (max_run !== int'(e)) begin
         bad++;
         $display("FAIL pwm_run_duty%0d: run=%0d expected=%0d", d, max_run, e);
      end
   endtask

   task automatic test_pwm();
      bus_write(2'd1, 32'h02, 4'h1);
      pwm_measure(8'd64, 128, 64);
      pwm_measure(8'd0, 0, 0);
      pwm_measure(8'd255, 510, 255);
   endtask

   task automatic test_byte_mask();
      logic [31:0] e;
      bus_write(2'd2, 32'h0, 4'hF);
      exp_q.push_back(32'h0);
      bus_cycle(4'h8, 32'h1122_3344, 4'b0101, 1'b1);
      e = exp_q.pop_front();
      total++;
      if (mem_rdata !== e) begin
         bad++;
         $display("FAIL rw_same_reg: rdata=%h expected=%h", mem_rdata, e);
      end
      read_check(2'd2, 32'h0022_0044, "duty_byte_mask");
      bus_write(2'd1, 32'hFFFF_FF1B, 4'b0010);
      read_check(2'd1, 32'h0000_0002, "mode_masked_lane");
   endtask

   task automatic test_reset_mid_blink();
      logic hit;
      bus_write(2'd3, 32'd3, 4'hF);
      bus_write(2'd0, 32'h1, 4'h1);
      bus_write(2'd1, 32'h01, 4'h1);
      read_check(2'd2, 32'h0022_0044, "duty_before_reset");
      hit = 1'b0;
      for (int n = 0; n < 40 && !hit; n++) begin
         @(negedge clk);
         if (leds_o[0]) hit = 1'b1;
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL mid_reset_wait: led0 high=%b expected=1", hit);
      end
      #2 resetn = 1'b0;
      #1;
      leds_check(4'b0000, "mid_reset_leds_async");
      total++;
      if (mem_rdata !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset_rdata: rdata=%h expected=0", mem_rdata);
      end
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      leds_check(4'b0000, "after_reset_leds");
      read_check(2'd3, DIV_RST, "after_reset_blink_div");
      read_check(2'd1, 32'h0, "after_reset_mode");
      read_check(2'd0, 32'h0, "after_reset_led_out");
      read_check(2'd2, 32'h0, "after_reset_duty");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_static();
      test_blink();
      test_pwm();
      test_byte_mask();
      test_reset_mid_blink();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
